axi_lite_cmd_master: RTL and testbench



---
 rtl/axi_lite_cmd_master.sv | 182 ++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AW+W or AR transaction out, one response back.
// Zero-wait slave gives rsp_valid three cycles after cmd accept; the result is held until rsp_ready.
module axi_lite_cmd_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_STAT_WIDTH       = 16
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_areset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_rnw,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready,
  output logic [C_STAT_WIDTH-1:0]           stat_wr_cnt,
  output logic [C_STAT_WIDTH-1:0]           stat_rd_cnt,
  output logic [C_STAT_WIDTH-1:0]           stat_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  localparam logic [C_STAT_WIDTH-1:0] STAT_ONE = 1;
  localparam logic [C_STAT_WIDTH-1:0] STAT_MAX = '1;

  state_t                            r_state;
  state_t                            w_next;
  logic                              r_awvalid;
  logic                              r_wvalid;
  logic                              r_aw_done;
  logic                              r_w_done;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_awaddr;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     r_araddr;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
  logic                              r_rsp_rnw;
  logic [C_M_AXI_DATA_WIDTH-1:0]     r_rsp_rdata;
  logic [1:0]                        r_rsp_resp;
  logic [C_STAT_WIDTH-1:0]           r_wr_cnt;
  logic [C_STAT_WIDTH-1:0]           r_rd_cnt;
  logic [C_STAT_WIDTH-1:0]           r_err_cnt;

  logic w_cmd_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_aw_done;
  logic w_w_done;

  assign w_cmd_hs  = (r_state == S_IDLE) && cmd_valid;
  assign w_aw_hs   = r_awvalid && m00_axi_awready;
  assign w_w_hs    = r_wvalid && m00_axi_wready;
  assign w_b_hs    = (r_state == S_WB) && m00_axi_bvalid;
  assign w_r_hs    = (r_state == S_RD) && m00_axi_rvalid;
  assign w_aw_done = r_aw_done || w_aw_hs;
  assign w_w_done  = r_w_done || w_w_hs;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = cmd_rnw ? S_RA : S_WR;
      S_WR:   if (w_aw_done && w_w_done) w_next = S_WB;
      S_WB:   if (m00_axi_bvalid) w_next = S_RSP;
      S_RA:   if (m00_axi_arready) w_next = S_RD;
      S_RD:   if (m00_axi_rvalid) w_next = S_RSP;
      S_RSP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (m00_axi_areset) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_awaddr    <= '0;
      r_araddr    <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_rnw   <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cmd_hs) begin
        if (cmd_rnw) begin
          r_araddr <= cmd_addr;
        end else begin
          r_awaddr  <= cmd_addr;
          r_wdata   <= cmd_wdata;
          r_wstrb   <= cmd_wstrb;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
      end
      // AW and W retire independently; the done flags remember which has gone
      if (w_aw_hs) begin
        r_awvalid <= 1'b0;
        r_aw_done <= 1'b1;
      end
      if (w_w_hs) begin
        r_wvalid <= 1'b0;
        r_w_done <= 1'b1;
      end
      if (w_b_hs) begin
        r_rsp_rnw   <= 1'b0;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m00_axi_bresp;
        if (r_wr_cnt != STAT_MAX) r_wr_cnt <= r_wr_cnt + STAT_ONE;
        if (m00_axi_bresp != 2'b00 && r_err_cnt != STAT_MAX) r_err_cnt <= r_err_cnt + STAT_ONE;
      end
      if (w_r_hs) begin
        r_rsp_rnw   <= 1'b1;
        r_rsp_rdata <= m00_axi_rdata;
        r_rsp_resp  <= m00_axi_rresp;
        if (r_rd_cnt != STAT_MAX) r_rd_cnt <= r_rd_cnt + STAT_ONE;
        if (m00_axi_rresp != 2'b00 && r_err_cnt != STAT_MAX) r_err_cnt <= r_err_cnt + STAT_ONE;
      end
    end
  end

  // Held off during reset so no command can be taken before the FSM is clean
  assign cmd_ready       = (r_state == S_IDLE) && !m00_axi_areset;
  assign rsp_valid       = (r_state == S_RSP);
  assign rsp_rnw         = r_rsp_rnw;
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_resp        = r_rsp_resp;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = r_wstrb;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = (r_state == S_WB);
  assign m00_axi_araddr  = r_araddr;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = (r_state == S_RA);
  assign m00_axi_rready  = (r_state == S_RD);
  assign stat_wr_cnt     = r_wr_cnt;
  assign stat_rd_cnt     = r_rd_cnt;
  assign stat_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: configurable-latency 4-register slave plus a saturation instance.
module tb_axi_lite_cmd_master;

  logic        clk = 1'b0;
  logic        areset;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_rnw;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [15:0] stat_wr, stat_rd, stat_err;

  axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_STAT_WIDTH(16)) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rnw(rsp_rnw), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .stat_wr_cnt(stat_wr), .stat_rd_cnt(stat_rd), .stat_err_cnt(stat_err)
  );

  // Second instance with 2-bit counters, read-only slave
  logic        d2_cmd_valid, d2_cmd_ready, d2_rsp_valid, d2_rsp_ready, d2_rsp_rnw;
  logic [31:0] d2_rsp_rdata, d2_awaddr, d2_wdata, d2_araddr;
  logic [1:0]  d2_rsp_resp;
  logic [2:0]  d2_awprot, d2_arprot;
  logic [3:0]  d2_wstrb;
  logic        d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready, d2_rvalid;
  logic [1:0]  d2_stat_wr, d2_stat_rd, d2_stat_err;

  axi_lite_cmd_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .C_STAT_WIDTH(2)) dut2 (
    .m00_axi_aclk(clk), .m00_axi_areset(areset),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_rnw(1'b1), .cmd_addr(32'h0000_0008),
    .cmd_wdata(32'h0), .cmd_wstrb(4'h0),
    .rsp_valid(d2_rsp_valid), .rsp_ready(d2_rsp_ready), .rsp_rnw(d2_rsp_rnw), .rsp_rdata(d2_rsp_rdata),
    .rsp_resp(d2_rsp_resp),
    .m00_axi_awaddr(d2_awaddr), .m00_axi_awprot(d2_awprot), .m00_axi_awvalid(d2_awvalid), .m00_axi_awready(1'b0),
    .m00_axi_wdata(d2_wdata), .m00_axi_wstrb(d2_wstrb), .m00_axi_wvalid(d2_wvalid), .m00_axi_wready(1'b0),
    .m00_axi_bresp(2'b00), .m00_axi_bvalid(1'b0), .m00_axi_bready(d2_bready),
    .m00_axi_araddr(d2_araddr), .m00_axi_arprot(d2_arprot), .m00_axi_arvalid(d2_arvalid), .m00_axi_arready(1'b1),
    .m00_axi_rdata(32'h5A5A_5A5A), .m00_axi_rresp(2'b00), .m00_axi_rvalid(d2_rvalid), .m00_axi_rready(d2_rready),
    .stat_wr_cnt(d2_stat_wr), .stat_rd_cnt(d2_stat_rd), .stat_err_cnt(d2_stat_err)
  );

  always @(posedge clk) begin
    if (areset) d2_rvalid <= 1'b0;
    else if (d2_arvalid) d2_rvalid <= 1'b1;
    else if (d2_rvalid && d2_rready) d2_rvalid <= 1'b0;
  end

  // ---------------- main slave model ----------------
  int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_wait, cfg_r_wait;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] s_mem [4];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, s_wr_count;
  logic        s_got_aw, s_got_w, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  assign awready = awvalid && (aw_cnt >= cfg_aw_wait);
  assign wready  = wvalid && (w_cnt >= cfg_w_wait);
  assign arready = arvalid && (ar_cnt >= cfg_ar_wait);
  assign bresp   = cfg_bresp;
  assign rresp   = cfg_rresp;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = s[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return m;
  endfunction

  always @(posedge clk) begin
    if (areset) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      s_got_aw <= 1'b0; s_got_w <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0;
      s_wr_count <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (awvalid && awready) begin s_got_aw <= 1'b1; s_awaddr <= awaddr; end
      if (wvalid && wready) begin s_got_w <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
      if ((s_got_aw || (awvalid && awready)) && (s_got_w || (wvalid && wready))) begin
        if (awvalid && awready) begin
          if (wvalid && wready) s_mem[awaddr[3:2]] <= merge(s_mem[awaddr[3:2]], wdata, wstrb);
          else s_mem[awaddr[3:2]] <= merge(s_mem[awaddr[3:2]], s_wdata, s_wstrb);
        end else begin
          if (wvalid && wready) s_mem[s_awaddr[3:2]] <= merge(s_mem[s_awaddr[3:2]], wdata, wstrb);
          else s_mem[s_awaddr[3:2]] <= merge(s_mem[s_awaddr[3:2]], s_wdata, s_wstrb);
        end
        s_wr_count <= s_wr_count + 1;
        s_got_aw <= 1'b0;
        s_got_w  <= 1'b0;
        if (cfg_b_wait == 0) bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= 1; end
      end
      if (b_pend) begin
        if (b_cnt >= cfg_b_wait) begin bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt + 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rdata <= s_mem[araddr[3:2]];
        if (cfg_r_wait == 0) rvalid <= 1'b1;
        else begin r_pend <= 1'b1; r_cnt <= 1; end
      end
      if (r_pend) begin
        if (r_cnt >= cfg_r_wait) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        else r_cnt <= r_cnt + 1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- bus monitor (cumulative counters) ----------------
  int   mon_aw_cyc = 0, mon_w_cyc = 0, mon_ar_cyc = 0, mon_b_cyc = 0, mon_unstable = 0, mon_early = 0;
  logic p_awvalid = 1'b0, p_wvalid = 1'b0, p_arvalid = 1'b0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;

  always @(negedge clk) begin
    if (awvalid) mon_aw_cyc <= mon_aw_cyc + 1;
    if (wvalid)  mon_w_cyc  <= mon_w_cyc + 1;
    if (arvalid) mon_ar_cyc <= mon_ar_cyc + 1;
    if (bready)  mon_b_cyc  <= mon_b_cyc + 1;
    if ((awvalid && p_awvalid && awaddr !== p_awaddr) ||
        (wvalid && p_wvalid && (wdata !== p_wdata || wstrb !== p_wstrb)) ||
        (arvalid && p_arvalid && araddr !== p_araddr) ||
        ((awvalid || arvalid || wvalid) && (awprot !== 3'b000 || arprot !== 3'b000)))
      mon_unstable <= mon_unstable + 1;
    if ((bready && (awvalid || wvalid)) || (rready && arvalid)) mon_early <= mon_early + 1;
    p_awvalid <= awvalid; p_wvalid <= wvalid; p_arvalid <= arvalid;
    p_awaddr <= awaddr; p_wdata <= wdata; p_wstrb <= wstrb; p_araddr <= araddr;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        rnw;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_mem [4];
  int          errors = 0;
  int          checks = 0;

  task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output int lat);
    exp_t        e;
    int          k;
    int          bad;
    logic [31:0] hd;
    logic [1:0]  hr;
    logic        hn;
    e.rnw = rnw;
    if (rnw) begin
      e.rdata = exp_mem[addr[3:2]];
      e.resp  = cfg_rresp;
    end else begin
      e.rdata = 32'h0;
      e.resp  = cfg_bresp;
      exp_mem[addr[3:2]] = wd;
    end
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = 4'hF;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept addr=%h: cmd_ready=%b required 1", addr, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout addr=%h: rsp_valid=%b required 1", addr, rsp_valid);
      void'(sb.pop_front());
      return;
    end
    hd = rsp_rdata; hr = rsp_resp; hn = rsp_rnw; bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== hd || rsp_resp !== hr || rsp_rnw !== hn || cmd_ready !== 1'b0) bad++;
    end
    if (hold > 0) begin
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rsp_hold: %0d unstable cycles, required 0", bad); end
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    checks++;
    if (rsp_rnw !== e.rnw) begin errors++; $display("FAIL rsp_rnw addr=%h: got %b required %b", addr, rsp_rnw, e.rnw); end
    checks++;
    if (rsp_rdata !== e.rdata) begin errors++; $display("FAIL rsp_rdata addr=%h: got %h required %h", addr, rsp_rdata, e.rdata); end
    checks++;
    if (rsp_resp !== e.resp) begin errors++; $display("FAIL rsp_resp addr=%h: got %0d required %0d", addr, rsp_resp, e.resp); end
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL back_to_idle: cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || {awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes: cmd_ready=%b valids/readys=%b required 0", cmd_ready,
                         {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    checks++;
    if ({awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp, rsp_rnw} !== '0 || {stat_wr, stat_rd, stat_err} !== '0) begin
      errors++; $display("FAIL reset_values: payload/counters not zero (wr=%0d rd=%0d err=%0d)", stat_wr, stat_rd, stat_err);
    end
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_loopback();
    logic [31:0] pat [4];
    int lat;
    pat[0] = 32'h0101_FFFF; pat[1] = 32'hABCD_0001; pat[2] = 32'hDEAD_0011; pat[3] = 32'hBEEF_0011;
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b0, 32'(i * 4), pat[i], 0, lat);
      run_cmd(1'b1, 32'(i * 4), 32'h0, 0, lat);
    end
    checks++;
    if (stat_wr !== 16'd4 || stat_rd !== 16'd4 || stat_err !== 16'd0) begin
      errors++; $display("FAIL loopback_stats: wr=%0d rd=%0d err=%0d required 4/4/0", stat_wr, stat_rd, stat_err);
    end
  endtask

  task automatic test_latency();
    int lat, aw0, w0, ar0, b0;
    aw0 = mon_aw_cyc; w0 = mon_w_cyc; b0 = mon_b_cyc;
    run_cmd(1'b0, 32'h8, 32'h1234_5678, 0, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL write_latency: rsp_valid at T%0d required T3", lat); end
    checks++;
    if (mon_aw_cyc - aw0 != 1 || mon_w_cyc - w0 != 1 || mon_b_cyc - b0 != 1) begin
      errors++; $display("FAIL write_phases: aw=%0d w=%0d b=%0d cycles required 1/1/1",
                         mon_aw_cyc - aw0, mon_w_cyc - w0, mon_b_cyc - b0);
    end
    ar0 = mon_ar_cyc;
    run_cmd(1'b1, 32'h8, 32'h0, 0, lat);
    checks++;
    if (lat != 3 || mon_ar_cyc - ar0 != 1) begin
      errors++; $display("FAIL read_latency: rsp_valid at T%0d ar=%0d cycles required T3/1", lat, mon_ar_cyc - ar0);
    end
  endtask

  task automatic test_skew();
    int lat, aw0, w0, wr0, e0;
    cfg_w_wait = 5;
    aw0 = mon_aw_cyc; w0 = mon_w_cyc; wr0 = s_wr_count; e0 = mon_early;
    run_cmd(1'b0, 32'hC, 32'hCAFE_F00D, 0, lat);
    cfg_w_wait = 0;
    checks++;
    if (mon_aw_cyc - aw0 != 1 || mon_w_cyc - w0 != 6) begin
      errors++; $display("FAIL skew_valids: aw=%0d w=%0d cycles required 1/6", mon_aw_cyc - aw0, mon_w_cyc - w0);
    end
    checks++;
    if (mon_early - e0 != 0 || s_wr_count - wr0 != 1) begin
      errors++; $display("FAIL skew_bready: early=%0d writes=%0d required 0/1", mon_early - e0, s_wr_count - wr0);
    end
    run_cmd(1'b1, 32'hC, 32'h0, 0, lat);
  endtask

  task automatic test_backpressure();
    int lat, ar0;
    cfg_ar_wait = 3; cfg_r_wait = 4;
    ar0 = mon_ar_cyc;
    run_cmd(1'b1, 32'h4, 32'h0, 10, lat);
    cfg_ar_wait = 0; cfg_r_wait = 0;
    checks++;
    if (mon_ar_cyc - ar0 != 4) begin errors++; $display("FAIL bp_arvalid: %0d cycles required 4", mon_ar_cyc - ar0); end
    checks++;
    if (mon_unstable != 0 || mon_early != 0) begin
      errors++; $display("FAIL bus_stability: unstable=%0d early=%0d required 0/0", mon_unstable, mon_early);
    end
  endtask

  task automatic test_error();
    int lat;
    cfg_bresp = 2'b10;
    run_cmd(1'b0, 32'h8, 32'h0BAD_0BAD, 0, lat);
    cfg_bresp = 2'b00; cfg_rresp = 2'b11;
    run_cmd(1'b1, 32'h8, 32'h0, 0, lat);
    cfg_rresp = 2'b00;
    checks++;
    if (stat_err !== 16'd2) begin errors++; $display("FAIL err_count: got %0d required 2", stat_err); end
  endtask

  task automatic test_reset_mid_write();
    int k, lat;
    cfg_b_wait = 30;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rnw = 1'b0; cmd_addr = 32'h4; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (!bready && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (bready !== 1'b1) begin errors++; $display("FAIL midrst_reach_wb: bready=%b required 1", bready); end
    areset = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready} !== 7'b0) begin
      errors++; $display("FAIL midrst_handshakes: %b required 0", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready});
    end
    checks++;
    if ({stat_wr, stat_rd, stat_err} !== '0) begin
      errors++; $display("FAIL midrst_counters: wr=%0d rd=%0d err=%0d required 0", stat_wr, stat_rd, stat_err);
    end
    cfg_b_wait = 0;
    areset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_release: cmd_ready=%b required 1", cmd_ready); end
    run_cmd(1'b0, 32'h4, 32'hABCD_0001, 0, lat);
    run_cmd(1'b1, 32'h4, 32'h0, 0, lat);
    checks++;
    if (stat_wr !== 16'd1 || stat_rd !== 16'd1) begin
      errors++; $display("FAIL midrst_stats: wr=%0d rd=%0d required 1/1", stat_wr, stat_rd);
    end
  endtask

  task automatic test_saturation();
    int k;
    exp_t e;
    for (int n = 1; n <= 5; n++) begin
      e.rnw = 1'b1; e.rdata = 32'h5A5A_5A5A; e.resp = 2'b00;
      sb.push_back(e);
      @(negedge clk);
      d2_cmd_valid = 1'b1;
      k = 0;
      while (!d2_cmd_ready && k < 50) begin @(negedge clk); k++; end
      @(negedge clk);
      d2_cmd_valid = 1'b0;
      k = 0;
      while (!d2_rsp_valid && k < 50) begin @(negedge clk); k++; end
      e = sb.pop_front();
      checks++;
      if (d2_rsp_valid !== 1'b1 || d2_rsp_rdata !== e.rdata || d2_rsp_rnw !== e.rnw) begin
        errors++; $display("FAIL sat_rsp #%0d: valid=%b rdata=%h required 1/%h", n, d2_rsp_valid, d2_rsp_rdata, e.rdata);
      end
      d2_rsp_ready = 1'b1;
      @(negedge clk);
      d2_rsp_ready = 1'b0;
      checks++;
      if (d2_stat_rd !== 2'((n > 3) ? 3 : n)) begin
        errors++; $display("FAIL sat_rd_cnt #%0d: got %0d required %0d", n, d2_stat_rd, (n > 3) ? 3 : n);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0; d2_cmd_valid = 1'b0; d2_rsp_ready = 1'b0;
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_b_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    test_reset();
    test_loopback();
    test_latency();
    test_skew();
    test_backpressure();
    test_error();
    test_reset_mid_write();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
